// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and types for the decode/writeback register stage.
package y86_pkg;

   typedef logic [3:0] reg_id_t;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam reg_id_t RRSP  = 4'h4;
   localparam reg_id_t RNONE = 4'hF;

   localparam int unsigned NUM_REGS = 15;

endpackage

// File: rtl/regfile_2r2w.sv
// 15-entry register file: two async read ports, a debug read port and two
// write ports where port M overrides port E on an address collision.
module regfile_2r2w
   import y86_pkg::*;
#(
   parameter int unsigned         DATA_W   = 64,
   parameter logic [DATA_W-1:0]   RSP_INIT = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        rd_a_id,
   output logic [DATA_W-1:0] rd_a_val,
   input  logic [3:0]        rd_b_id,
   output logic [DATA_W-1:0] rd_b_val,
   input  logic [3:0]        rd_dbg_id,
   output logic [DATA_W-1:0] rd_dbg_val,
   input  logic              we_e,
   input  logic [3:0]        wr_e_id,
   input  logic [DATA_W-1:0] wr_e_val,
   input  logic              we_m,
   input  logic [3:0]        wr_m_id,
   input  logic [DATA_W-1:0] wr_m_val
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];

   // Port M is applied last so it wins when both ports target one register.
   always_comb begin
      regs_d = regs_q;
      if (we_e && (wr_e_id != RNONE)) regs_d[wr_e_id] = wr_e_val;
      if (we_m && (wr_m_id != RNONE)) regs_d[wr_m_id] = wr_m_val;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= (i == 32'(RRSP)) ? RSP_INIT : '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rd_a_val   = (rd_a_id   == RNONE) ? '0 : regs_q[rd_a_id];
   assign rd_b_val   = (rd_b_id   == RNONE) ? '0 : regs_q[rd_b_id];
   assign rd_dbg_val = (rd_dbg_id == RNONE) ? '0 : regs_q[rd_dbg_id];

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode/writeback: register ID decode, regfile reads, gated commit
// and sticky halt. Define WB_BYPASS_EN to forward same-cycle write data to valA/valB.
module decode_writeback
   import y86_pkg::*;
#(
   parameter int unsigned       DATA_W   = 64,
   parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        icode,
   input  logic [3:0]        rA,
   input  logic [3:0]        rB,
   input  logic              instr_valid,
   input  logic              imem_error,
   input  logic              halt,
   input  logic              cnd,
   input  logic              wb_en,
   input  logic [DATA_W-1:0] valE,
   input  logic [DATA_W-1:0] valM,
   output logic [3:0]        srcA,
   output logic [3:0]        srcB,
   output logic [3:0]        dstE,
   output logic [3:0]        dstM,
   output logic [DATA_W-1:0] valA,
   output logic [DATA_W-1:0] valB,
   output logic              halted,
   input  logic [3:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_val
);

   typedef enum logic {
      S_RUN    = 1'b0,
      S_HALTED = 1'b1
   } state_t;

   state_t state_q;
   state_t state_d;
   logic   stop_c;
   logic   commit_c;
   logic [DATA_W-1:0] rf_a_val;
   logic [DATA_W-1:0] rf_b_val;

   // Register ID decode from the fetched instruction fields.
   always_comb begin
      srcA = RNONE;
      srcB = RNONE;
      dstE = RNONE;
      dstM = RNONE;
      case (icode)
         IRRMOVQ: begin
            srcA = rA;
            dstE = cnd ? rB : RNONE;
         end
         IIRMOVQ: dstE = rB;
         IRMMOVQ: begin
            srcA = rA;
            srcB = rB;
         end
         IMRMOVQ: begin
            srcB = rB;
            dstM = rA;
         end
         IOPQ: begin
            srcA = rA;
            srcB = rB;
            dstE = rB;
         end
         ICALL: begin
            srcB = RRSP;
            dstE = RRSP;
         end
         IRET: begin
            srcA = RRSP;
            srcB = RRSP;
            dstE = RRSP;
         end
         IPUSHQ: begin
            srcA = rA;
            srcB = RRSP;
            dstE = RRSP;
         end
         IPOPQ: begin
            srcA = RRSP;
            srcB = RRSP;
            dstE = RRSP;
            dstM = rA;
         end
         default: ;
      endcase
   end

   // The instruction that trips the halt condition must not write either.
   assign stop_c   = halt | imem_error | ~instr_valid;
   assign commit_c = wb_en & ~stop_c & (state_q == S_RUN);

   always_comb begin
      state_d = state_q;
      if ((state_q == S_RUN) && stop_c) state_d = S_HALTED;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_RUN;
      else     state_q <= state_d;
   end

   assign halted = (state_q == S_HALTED);

   regfile_2r2w #(
      .DATA_W   (DATA_W),
      .RSP_INIT (RSP_INIT)
   ) u_regfile (
      .clk        (clk),
      .rst        (rst),
      .rd_a_id    (srcA),
      .rd_a_val   (rf_a_val),
      .rd_b_id    (srcB),
      .rd_b_val   (rf_b_val),
      .rd_dbg_id  (dbg_sel),
      .rd_dbg_val (dbg_val),
      .we_e       (commit_c),
      .wr_e_id    (dstE),
      .wr_e_val   (valE),
      .we_m       (commit_c),
      .wr_m_id    (dstM),
      .wr_m_val   (valM)
   );

`ifdef WB_BYPASS_EN
   // Forward pending write data; dstM has priority to match the regfile collision rule.
   always_comb begin
      valA = rf_a_val;
      valB = rf_b_val;
      if (commit_c && (srcA != RNONE)) begin
         if (srcA == dstM)      valA = valM;
         else if (srcA == dstE) valA = valE;
      end
      if (commit_c && (srcB != RNONE)) begin
         if (srcB == dstM)      valB = valM;
         else if (srcB == dstE) valB = valE;
      end
   end
`else
   assign valA = rf_a_val;
   assign valB = rf_b_val;
`endif

endmodule

// File: tb/tb_decode_writeback.sv
// Scoreboard bench for decode_writeback: directed plus random vectors against
// an array-based architectural model.
module tb_decode_writeback;

   localparam logic [63:0] RSP_INIT_TB = 64'h0000_0000_0000_0F00;

   logic        clk;
   logic        rst;
   logic [3:0]  icode, rA, rB, dbg_sel;
   logic        instr_valid, imem_error, halt, cnd, wb_en;
   logic [63:0] valE, valM;
   logic [3:0]  srcA, srcB, dstE, dstM;
   logic [63:0] valA, valB, dbg_val;
   logic        halted;

   decode_writeback #(.DATA_W(64), .RSP_INIT(RSP_INIT_TB)) dut (
      .clk(clk), .rst(rst), .icode(icode), .rA(rA), .rB(rB),
      .instr_valid(instr_valid), .imem_error(imem_error), .halt(halt),
      .cnd(cnd), .wb_en(wb_en), .valE(valE), .valM(valM),
      .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
      .valA(valA), .valB(valB), .halted(halted),
      .dbg_sel(dbg_sel), .dbg_val(dbg_val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  icode, rA, rB, dbg_sel;
      logic        iv, ime, halt, cnd, wb_en;
      logic [63:0] valE, valM;
   } vec_t;

   typedef struct {
      int          id;
      logic [3:0]  srcA, srcB, dstE, dstM;
      logic [63:0] valA, valB, dbg;
      logic        halted;
   } exp_t;

   exp_t        sb_q[$];
   logic [63:0] m_regs [15];
   logic        m_halted;
   int          n_vec;
   int          n_bad;
   int          n_issued;

   function automatic logic [63:0] m_read(input logic [3:0] id);
      return (id == 4'hF) ? 64'd0 : m_regs[id];
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 15; i++) m_regs[i] = (i == 4) ? RSP_INIT_TB : 64'd0;
      m_halted = 1'b0;
   endtask

   // Issue one vector: drive, predict, push prediction, then advance the model.
   task automatic apply(input vec_t v);
      exp_t        e;
      logic [3:0]  sa, sb, de, dm;
      logic        commit;
      @(posedge clk);
      #1;
      rst = v.rst; icode = v.icode; rA = v.rA; rB = v.rB; dbg_sel = v.dbg_sel;
      instr_valid = v.iv; imem_error = v.ime; halt = v.halt; cnd = v.cnd;
      wb_en = v.wb_en; valE = v.valE; valM = v.valM;
      if (v.rst) m_reset();

      sa = (v.icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? v.rA :
           (v.icode inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
      sb = (v.icode inside {4'h4, 4'h5, 4'h6}) ? v.rB :
           (v.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
      de = (v.icode inside {4'h3, 4'h6}) ? v.rB :
           (v.icode == 4'h2) ? (v.cnd ? v.rB : 4'hF) :
           (v.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
      dm = (v.icode inside {4'h5, 4'hB}) ? v.rA : 4'hF;
      commit = !v.rst && v.wb_en && !m_halted && v.iv && !v.ime && !v.halt;

      e.id = n_issued; e.srcA = sa; e.srcB = sb; e.dstE = de; e.dstM = dm;
      e.valA = m_read(sa); e.valB = m_read(sb); e.dbg = m_read(v.dbg_sel);
      e.halted = m_halted;
`ifdef WB_BYPASS_EN
      if (commit && sa != 4'hF) begin
         if (sa == dm) e.valA = v.valM; else if (sa == de) e.valA = v.valE;
      end
      if (commit && sb != 4'hF) begin
         if (sb == dm) e.valB = v.valM; else if (sb == de) e.valB = v.valE;
      end
`endif
      sb_q.push_back(e);
      n_issued++;

      if (!v.rst) begin
         if (commit) begin
            if (de != 4'hF) m_regs[de] = v.valE;
            if (dm != 4'hF) m_regs[dm] = v.valM;
         end
         if (!m_halted && (v.halt || v.ime || !v.iv)) m_halted = 1'b1;
      end
   endtask

   function automatic vec_t nop_vec();
      vec_t v;
      v.rst = 0; v.icode = 4'h1; v.rA = 4'hF; v.rB = 4'hF; v.dbg_sel = 4'h0;
      v.iv = 1; v.ime = 0; v.halt = 0; v.cnd = 0; v.wb_en = 0;
      v.valE = 64'd0; v.valM = 64'd0;
      return v;
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      v.rst     = ($urandom_range(0, 24) == 0);
      v.icode   = 4'($urandom_range(0, 15));
      v.rA      = 4'($urandom_range(0, 15));
      v.rB      = 4'($urandom_range(0, 15));
      v.dbg_sel = 4'($urandom_range(0, 15));
      v.iv      = ($urandom_range(0, 149) != 0);
      v.ime     = ($urandom_range(0, 149) == 0);
      v.halt    = ($urandom_range(0, 99) == 0);
      v.cnd     = 1'($urandom);
      v.wb_en   = ($urandom_range(0, 3) != 0);
      v.valE    = {$urandom, $urandom};
      v.valM    = {$urandom, $urandom};
      return v;
   endfunction

   task automatic chk(input int id, input string nm, input logic [63:0] got, input logic [63:0] exp);
      if (got !== exp) begin
         n_bad++;
         $display("FAIL vec%0d %s: got %h expected %h", id, nm, got, exp);
      end
   endtask

   // Monitor: outputs are settled mid-cycle, compare on every falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_vec++;
            chk(e.id, "srcA",    64'(srcA),    64'(e.srcA));
            chk(e.id, "srcB",    64'(srcB),    64'(e.srcB));
            chk(e.id, "dstE",    64'(dstE),    64'(e.dstE));
            chk(e.id, "dstM",    64'(dstM),    64'(e.dstM));
            chk(e.id, "valA",    valA,         e.valA);
            chk(e.id, "valB",    valB,         e.valB);
            chk(e.id, "dbg_val", dbg_val,      e.dbg);
            chk(e.id, "halted",  64'(halted),  64'(e.halted));
         end
      end
   end

   initial begin
      vec_t v;
      int   wait_cycles;
      n_vec = 0; n_bad = 0; n_issued = 0;
      rst = 1; icode = 0; rA = 0; rB = 0; dbg_sel = 0; instr_valid = 1;
      imem_error = 0; halt = 0; cnd = 0; wb_en = 0; valE = 0; valM = 0;
      m_reset();

      // Reset contents sweep through the debug port.
      v = nop_vec(); v.rst = 1; apply(v);
      for (int i = 0; i < 16; i++) begin
         v = nop_vec(); v.dbg_sel = 4'(i); apply(v);
      end
      // irmovq into r2, then opq reading r2 on both sides.
      v = nop_vec(); v.icode = 4'h3; v.rB = 4'h2; v.valE = 64'h1234; v.wb_en = 1; v.dbg_sel = 4'h2; apply(v);
      v = nop_vec(); v.icode = 4'h6; v.rA = 4'h2; v.rB = 4'h2; v.dbg_sel = 4'h2; apply(v);
      // cmov not taken, then taken.
      v = nop_vec(); v.icode = 4'h2; v.rA = 4'h1; v.rB = 4'h3; v.valE = 64'd5; v.wb_en = 1; v.dbg_sel = 4'h3; apply(v);
      v = nop_vec(); v.dbg_sel = 4'h3; apply(v);
      v = nop_vec(); v.icode = 4'h2; v.rA = 4'h1; v.rB = 4'h3; v.cnd = 1; v.valE = 64'd5; v.wb_en = 1; v.dbg_sel = 4'h3; apply(v);
      v = nop_vec(); v.dbg_sel = 4'h3; apply(v);
      // popq %rsp: valM wins over valE.
      v = nop_vec(); v.icode = 4'hB; v.rA = 4'h4; v.valE = 64'h108; v.valM = 64'hAB; v.wb_en = 1; v.dbg_sel = 4'h4; apply(v);
      v = nop_vec(); v.dbg_sel = 4'h4; apply(v);
      // Same-cycle read of a pending write (forwarded only with bypass).
      v = nop_vec(); v.icode = 4'h6; v.rA = 4'h5; v.rB = 4'h5; v.valE = 64'd7; v.wb_en = 1; v.dbg_sel = 4'h5; apply(v);
      // Halt with a write attempt, then suppressed write, then reset.
      v = nop_vec(); v.icode = 4'h0; v.halt = 1; v.wb_en = 1; v.icode = 4'h3; v.rB = 4'h6; v.valE = 64'h77; apply(v);
      v = nop_vec(); v.icode = 4'h3; v.rB = 4'h1; v.valE = 64'd9; v.wb_en = 1; v.dbg_sel = 4'h1; apply(v);
      v = nop_vec(); v.dbg_sel = 4'h1; apply(v);
      v = nop_vec(); v.dbg_sel = 4'h6; apply(v);
      v = nop_vec(); v.rst = 1; v.dbg_sel = 4'h4; apply(v);
      v = nop_vec(); v.dbg_sel = 4'h4; apply(v);

      for (int n = 0; n < 2000; n++) apply(rand_vec());

      wait_cycles = 0;
      while (sb_q.size() != 0 && wait_cycles < 20) begin
         @(posedge clk);
         wait_cycles++;
      end
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
